boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader_pkg.sv | 18 +
 rtl/imem_ram.sv | 25 ++
 rtl/boot_loader.sv | 126 ++++++++++++
 tb/tb_boot_loader.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and sizing for the serial boot loader and its instruction memory.
package boot_loader_pkg;

    localparam int unsigned INS_W          = 21;
    localparam int unsigned DEPTH          = 256;
    localparam int unsigned ADDR_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction memory: synchronous write, asynchronous read, never cleared.
module imem_ram #(
    parameter int unsigned INS_W  = 21,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [INS_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [INS_W-1:0]  rdata
);

    logic [INS_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/boot_loader.sv
// Loads a byte-serial program (count, 3-byte words, XOR checksum) into
// instruction memory and releases the CPU from reset on success.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned INS_W = boot_loader_pkg::INS_W,
    parameter int unsigned DEPTH = boot_loader_pkg::DEPTH
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [7:0]       Addr,
    output logic [INS_W-1:0] INS,
    output logic             cpu_reset,
    output logic             done,
    output logic             err
);

    state_e     state_q, state_d;
    logic [7:0] wr_addr_q;
    logic [1:0] byte_idx_q;
    logic [8:0] words_left_q;
    logic [7:0] csum_q;
    logic [7:0] b0_q, b1_q;

    logic             accept_c;
    logic             word_done_c;
    logic             hi_ok_c;
    logic             we_c;
    logic [INS_W-1:0] wdata_c;
    logic [INS_W-1:0] rdata_c;

    assign accept_c    = rx_valid & rx_ready;
    assign word_done_c = accept_c && (state_q == ST_LOAD)
                         && (byte_idx_q == 2'(BYTES_PER_WORD - 1));
    assign hi_ok_c     = (rx_data[7:5] == 3'b000);
    assign we_c        = word_done_c & hi_ok_c;
    assign wdata_c     = INS_W'({rx_data[4:0], b1_q, b0_q});

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_COUNT;
            ST_COUNT: if (accept_c) state_d = ST_LOAD;
            ST_LOAD: begin
                if (word_done_c) begin
                    if (!hi_ok_c) begin
                        state_d = ST_ERR;
                    end else if (words_left_q == 9'd1) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM:  if (accept_c) state_d = (rx_data == csum_q) ? ST_RUN : ST_ERR;
            ST_RUN,
            ST_ERR:   if (start) state_d = ST_COUNT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs derived from the next state
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rx_ready     <= 1'b0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            wr_addr_q    <= 8'd0;
            byte_idx_q   <= 2'd0;
            words_left_q <= 9'd0;
            csum_q       <= 8'd0;
            b0_q         <= 8'd0;
            b1_q         <= 8'd0;
        end else begin
            state_q   <= state_d;
            rx_ready  <= (state_d == ST_COUNT) || (state_d == ST_LOAD) || (state_d == ST_CSUM);
            cpu_reset <= (state_d != ST_RUN);
            done      <= (state_d == ST_RUN);
            err       <= (state_d == ST_ERR);

            if (accept_c && (state_q == ST_COUNT)) begin
                words_left_q <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                wr_addr_q    <= 8'd0;
                byte_idx_q   <= 2'd0;
                csum_q       <= rx_data;
            end

            if (accept_c && (state_q == ST_LOAD)) begin
                csum_q <= csum_q ^ rx_data;
                if (byte_idx_q == 2'd0) b0_q <= rx_data;
                if (byte_idx_q == 2'd1) b1_q <= rx_data;
                if (word_done_c) begin
                    byte_idx_q <= 2'd0;
                    if (hi_ok_c) begin
                        wr_addr_q    <= 8'(wr_addr_q + 8'd1);
                        words_left_q <= 9'(words_left_q - 9'd1);
                    end
                end else begin
                    byte_idx_q <= 2'(byte_idx_q + 2'd1);
                end
            end
        end
    end

    imem_ram #(
        .INS_W  (INS_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (CLK),
        .we    (we_c),
        .waddr (wr_addr_q),
        .wdata (wdata_c),
        .raddr (Addr),
        .rdata (rdata_c)
    );

    // CPU sees zeros while held in reset
    assign INS = cpu_reset ? '0 : rdata_c;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: load, checksum/format errors, backpressure,
// mid-load reset and reload, all against hand-computed values.
module tb_boot_loader;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  Addr;
    logic [20:0] INS;
    logic        cpu_reset;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] stim [$];

    boot_loader #(.INS_W(21), .DEPTH(256)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .Addr      (Addr),
        .INS       (INS),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Offer one byte and hold it until the loader takes it (bounded wait)
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int waited;
        if (gap) @(negedge CLK);
        @(negedge CLK);
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (!rx_ready && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        if (!rx_ready) begin
            check("rx_ready_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
        end else begin
            @(posedge CLK);
            #1 rx_valid = 1'b0;
        end
    endtask

    task automatic send_stim(input bit gap);
        foreach (stim[i]) send_byte(stim[i], gap);
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic read_ins(input string tag, input logic [7:0] a, input logic [20:0] exp);
        Addr = a;
        #1 check(tag, 32'(INS), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; Addr = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_rx_ready",  32'(rx_ready),  32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_ins",       32'(INS),       32'd0);
        @(negedge CLK);
        reset = 1'b0;

        // Bytes offered in IDLE are not taken
        rx_data = 8'h55; rx_valid = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("idle_rx_ready", 32'(rx_ready), 32'd0);
        check("idle_done",     32'(done),     32'd0);
        rx_valid = 1'b0;

        // Normal two-word load
        pulse_start();
        check("start_rx_ready", 32'(rx_ready),  32'd1);
        check("start_cpu_rst",  32'(cpu_reset), 32'd1);
        stim = '{8'h02, 8'h05, 8'h00, 8'h0C, 8'h07, 8'h08, 8'h0C};
        send_stim(1'b0);
        check("pre_cs_done", 32'(done), 32'd0);
        send_byte(8'h08, 1'b0);
        check("load_done",     32'(done),      32'd1);
        check("load_cpu_rst",  32'(cpu_reset), 32'd0);
        check("load_err",      32'(err),       32'd0);
        check("load_rx_ready", 32'(rx_ready),  32'd0);
        read_ins("load_ins0", 8'd0, 21'h0C0005);
        read_ins("load_ins1", 8'd1, 21'h0C0807);

        // Bad checksum from RUN
        pulse_start();
        check("restart_cpu_rst", 32'(cpu_reset), 32'd1);
        check("restart_done",    32'(done),      32'd0);
        stim = '{8'h02, 8'h05, 8'h00, 8'h0C, 8'h07, 8'h08, 8'h0C, 8'h09};
        send_stim(1'b0);
        check("badcs_err",     32'(err),       32'd1);
        check("badcs_done",    32'(done),      32'd0);
        check("badcs_cpu_rst", 32'(cpu_reset), 32'd1);
        read_ins("badcs_ins0", 8'd0, 21'h0);
        read_ins("badcs_ins1", 8'd1, 21'h0);

        // Illegal high bits in b2, starting from ERR
        pulse_start();
        check("errstart_err",      32'(err),      32'd0);
        check("errstart_rx_ready", 32'(rx_ready), 32'd1);
        stim = '{8'h01, 8'h05, 8'h00, 8'h2C};
        send_stim(1'b0);
        check("hibits_err",      32'(err),      32'd1);
        check("hibits_rx_ready", 32'(rx_ready), 32'd0);
        check("hibits_done",     32'(done),     32'd0);
        check("hibits_mem0",     32'(dut.u_ram.mem[0]), 32'h0C0005);

        // Reset mid-load
        pulse_start();
        stim = '{8'h02, 8'h05, 8'h00, 8'h0C};
        send_stim(1'b0);
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK);
        #1;
        check("midrst_cpu_rst",  32'(cpu_reset), 32'd1);
        check("midrst_rx_ready", 32'(rx_ready),  32'd0);
        check("midrst_err",      32'(err),       32'd0);
        @(negedge CLK);
        reset = 1'b0;

        // Full load with rx_valid toggling, start pulsed mid-load (ignored)
        pulse_start();
        stim = '{8'h02, 8'h05, 8'h00};
        send_stim(1'b1);
        pulse_start();
        check("ignstart_rx_ready", 32'(rx_ready), 32'd1);
        stim = '{8'h0C, 8'h07, 8'h08, 8'h0C, 8'h08};
        send_stim(1'b1);
        check("bp_done",    32'(done),      32'd1);
        check("bp_cpu_rst", 32'(cpu_reset), 32'd0);
        read_ins("bp_ins0", 8'd0, 21'h0C0005);
        read_ins("bp_ins1", 8'd1, 21'h0C0807);

        // Reload one word from RUN
        pulse_start();
        check("reload_cpu_rst", 32'(cpu_reset), 32'd1);
        check("reload_done",    32'(done),      32'd0);
        stim = '{8'h01, 8'h11, 8'h22, 8'h03, 8'h31};
        send_stim(1'b0);
        check("reload_done_end", 32'(done), 32'd1);
        read_ins("reload_ins0", 8'd0, 21'h032211);
        read_ins("reload_ins1", 8'd1, 21'h0C0807);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
